inst_buffer: RTL and testbench

- Dual-slot instruction queue between the fetch stage (IF2 pre-decoder) and the dual-issue decoder.
- Accepts up to two fetched instructions per cycle, together with PC, branch-prediction info and fetch-side exception info.
- Presents the two oldest entries to the decoder. The decoder builds the per-instruction PC_set bundles from them.
- Decouples fetch from decode stalls, and discards all contents on a pipeline flush.

---
 rtl/inst_buffer.sv | 133 +++++++++++++
 tb/tb_inst_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// Dual-slot instruction queue between the IF2 pre-decoder and the dual-issue
// decoder. Up to two entries are accepted per cycle, the two oldest entries are
// presented first-word-fall-through, and a flush empties the queue at once.
//
// Handshake: a push happens on a rising edge when o_ready=1, i_flush=0 and
// i_valid is 2'b01 or 2'b11; o_ready depends only on the registered
// occupancy, so upstream must hold its data while o_ready=0. A pop happens on
// a rising edge for each requested head slot whose o_valid bit is set
// (i_pop 2'b01 = one, 2'b11 = two, 2'b10 = none).
module inst_buffer #(
   parameter int DEPTH = 16,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic [1:0]       i_valid,
   input  logic [31:0]      i_inst0,
   input  logic [31:0]      i_inst1,
   input  logic [31:0]      i_pc0,
   input  logic [31:0]      i_pc1,
   input  logic [31:0]      i_pc_pre0,
   input  logic [31:0]      i_pc_pre1,
   input  logic [1:0]       i_type_predict0,
   input  logic [1:0]       i_type_predict1,
   input  logic [6:0]       i_ecode0,
   input  logic [6:0]       i_ecode1,
   input  logic             i_ecode_we0,
   input  logic             i_ecode_we1,
   output logic             o_ready,
   input  logic [1:0]       i_pop,
   output logic [1:0]       o_valid,
   output logic [31:0]      o_inst0,
   output logic [31:0]      o_inst1,
   output logic [31:0]      o_pc0,
   output logic [31:0]      o_pc1,
   output logic [31:0]      o_pc_pre0,
   output logic [31:0]      o_pc_pre1,
   output logic [1:0]       o_type_predict0,
   output logic [1:0]       o_type_predict1,
   output logic [6:0]       o_ecode0,
   output logic [6:0]       o_ecode1,
   output logic             o_ecode_we0,
   output logic             o_ecode_we1,
   output logic [PTR_W:0]   o_count
);

   // Entry layout: {inst, pc, pc_pre, type_predict, ecode, ecode_we}
   localparam int EW = 106;

   logic [EW-1:0]    mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr_p1;
   logic [PTR_W-1:0] rd_ptr_p1;
   logic [PTR_W:0]   count;
   logic [PTR_W:0]   count_next;
   logic [1:0]       npush;
   logic [1:0]       npop;
   logic             push_en;
   logic [EW-1:0]    wdata0;
   logic [EW-1:0]    wdata1;
   logic [EW-1:0]    head0;
   logic [EW-1:0]    head1;

   assign wdata0 = {i_inst0, i_pc0, i_pc_pre0, i_type_predict0, i_ecode0, i_ecode_we0};
   assign wdata1 = {i_inst1, i_pc1, i_pc_pre1, i_type_predict1, i_ecode1, i_ecode_we1};

   // Pointers are PTR_W bits wide, so +1 wraps modulo DEPTH for free.
   assign wr_ptr_p1 = wr_ptr + PTR_W'(1);
   assign rd_ptr_p1 = rd_ptr + PTR_W'(1);

   // Ready and valid come from registered occupancy only; a same-cycle pop
   // never raises o_ready.
   assign o_ready    = (count <= (PTR_W+1)'(DEPTH - 2));
   assign o_valid[0] = (count != '0);
   assign o_valid[1] = (count >= (PTR_W+1)'(2));
   assign push_en    = o_ready & ~i_flush;
   assign o_count    = count;

   assign head0 = mem[rd_ptr];
   assign head1 = mem[rd_ptr_p1];

   assign {o_inst0, o_pc0, o_pc_pre0, o_type_predict0, o_ecode0, o_ecode_we0} = head0;
   assign {o_inst1, o_pc1, o_pc_pre1, o_type_predict1, o_ecode1, o_ecode_we1} = head1;

   // Decode push/pop requests into entry counts; illegal 2'b10 patterns count as zero.
   always_comb begin
      npush = 2'd0;
      npop  = 2'd0;
      if (push_en) begin
         case (i_valid)
            2'b11:   npush = 2'd2;
            2'b01:   npush = 2'd1;
            default: npush = 2'd0;
         endcase
      end
      case (i_pop)
         2'b11:   npop = o_valid[1] ? 2'd2 : {1'b0, o_valid[0]};
         2'b01:   npop = {1'b0, o_valid[0]};
         default: npop = 2'd0;
      endcase
      count_next = count + (PTR_W+1)'(npush) - (PTR_W+1)'(npop);
   end

   // Storage writes plus pointer/occupancy update; flush drops everything but
   // leaves stale storage in place since it is hidden behind count=0.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (npush != 2'd0) begin
            mem[wr_ptr] <= wdata0;
         end
         if (npush == 2'd2) begin
            mem[wr_ptr_p1] <= wdata1;
         end
         wr_ptr <= wr_ptr + PTR_W'(npush);
         rd_ptr <= rd_ptr + PTR_W'(npop);
         count  <= count_next;
      end
   end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed testbench for inst_buffer: reset state, first-word-fall-through,
// full/backpressure, wrap-around streaming, flush and field integrity.
module tb_inst_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_flush;
   logic [1:0]  i_valid;
   logic [31:0] i_inst0, i_inst1, i_pc0, i_pc1, i_pc_pre0, i_pc_pre1;
   logic [1:0]  i_type_predict0, i_type_predict1;
   logic [6:0]  i_ecode0, i_ecode1;
   logic        i_ecode_we0, i_ecode_we1;
   logic        o_ready;
   logic [1:0]  i_pop;
   logic [1:0]  o_valid;
   logic [31:0] o_inst0, o_inst1, o_pc0, o_pc1, o_pc_pre0, o_pc_pre1;
   logic [1:0]  o_type_predict0, o_type_predict1;
   logic [6:0]  o_ecode0, o_ecode1;
   logic        o_ecode_we0, o_ecode_we1;
   logic [4:0]  o_count;

   int vectors = 0;
   int miscompares = 0;

   inst_buffer #(.DEPTH(16)) dut (
      .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid),
      .i_inst0(i_inst0), .i_inst1(i_inst1), .i_pc0(i_pc0), .i_pc1(i_pc1),
      .i_pc_pre0(i_pc_pre0), .i_pc_pre1(i_pc_pre1),
      .i_type_predict0(i_type_predict0), .i_type_predict1(i_type_predict1),
      .i_ecode0(i_ecode0), .i_ecode1(i_ecode1),
      .i_ecode_we0(i_ecode_we0), .i_ecode_we1(i_ecode_we1),
      .o_ready(o_ready), .i_pop(i_pop), .o_valid(o_valid),
      .o_inst0(o_inst0), .o_inst1(o_inst1), .o_pc0(o_pc0), .o_pc1(o_pc1),
      .o_pc_pre0(o_pc_pre0), .o_pc_pre1(o_pc_pre1),
      .o_type_predict0(o_type_predict0), .o_type_predict1(o_type_predict1),
      .o_ecode0(o_ecode0), .o_ecode1(o_ecode1),
      .o_ecode_we0(o_ecode_we0), .o_ecode_we1(o_ecode_we1),
      .o_count(o_count)
   );

   // Clock: 10 ns period
   always #5 clk = ~clk;

   // One comparison point; outputs are sampled 1 ns after the active edge.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive push inputs; pc_pre is pc+4 and side-band fields are zero.
   task automatic set_push(input logic [1:0] v, input logic [31:0] inst0, input logic [31:0] pc0,
                           input logic [31:0] inst1, input logic [31:0] pc1);
      i_valid         = v;
      i_inst0         = inst0;
      i_pc0           = pc0;
      i_pc_pre0       = pc0 + 32'd4;
      i_inst1         = inst1;
      i_pc1           = pc1;
      i_pc_pre1       = pc1 + 32'd4;
      i_type_predict0 = 2'b00;
      i_type_predict1 = 2'b00;
      i_ecode0        = 7'h00;
      i_ecode1        = 7'h00;
      i_ecode_we0     = 1'b0;
      i_ecode_we1     = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      i_flush = 1'b0;
      i_pop   = 2'b00;
      set_push(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      step();
      step();
      rst = 1'b0;
      #1;

      // Reset state
      chk("rst_valid", 32'(o_valid), 32'h0);
      chk("rst_count", 32'(o_count), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_inst0", o_inst0, 32'h0);
      chk("rst_pc1", o_pc1, 32'h0);
      chk("rst_ecode_we0", 32'(o_ecode_we0), 32'h0);

      // First dual push appears next cycle
      set_push(2'b11, 32'h02800421, 32'h1C000000, 32'h02800842, 32'h1C000004);
      step();
      set_push(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      chk("p1_valid", 32'(o_valid), 32'h3);
      chk("p1_inst0", o_inst0, 32'h02800421);
      chk("p1_pc1", o_pc1, 32'h1C000004);
      chk("p1_inst1", o_inst1, 32'h02800842);
      chk("p1_pc_pre0", o_pc_pre0, 32'h1C000004);
      chk("p1_count", 32'(o_count), 32'd2);
      i_pop = 2'b11;
      step();
      i_pop = 2'b00;
      chk("p1_drain_count", 32'(o_count), 32'd0);
      chk("p1_drain_valid", 32'(o_valid), 32'h0);

      // Single push with exception/prediction side-band; leaves pointers odd
      set_push(2'b01, 32'h02800C63, 32'h1C000008, 32'h0, 32'h0);
      i_pc_pre0       = 32'h1C000100;
      i_type_predict0 = 2'b10;
      i_ecode0        = 7'h08;
      i_ecode_we0     = 1'b1;
      step();
      set_push(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      chk("ex_valid", 32'(o_valid), 32'h1);
      chk("ex_inst0", o_inst0, 32'h02800C63);
      chk("ex_pc0", o_pc0, 32'h1C000008);
      chk("ex_pc_pre0", o_pc_pre0, 32'h1C000100);
      chk("ex_type0", 32'(o_type_predict0), 32'h2);
      chk("ex_ecode0", 32'(o_ecode0), 32'h08);
      chk("ex_ecode_we0", 32'(o_ecode_we0), 32'h1);
      i_pop = 2'b11;
      step();
      i_pop = 2'b00;
      chk("ex_pop_count", 32'(o_count), 32'd0);
      chk("ex_pop_valid", 32'(o_valid), 32'h0);

      // Fill with 8 dual pushes, no pops
      for (int k = 0; k < 8; k++) begin
         chk("fill_ready", 32'(o_ready), 32'd1);
         set_push(2'b11, 32'h100 + 32'(2*k), 32'h1C001000 + 32'(8*k),
                  32'h101 + 32'(2*k), 32'h1C001004 + 32'(8*k));
         step();
      end
      set_push(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      chk("full_count", 32'(o_count), 32'd16);
      chk("full_ready", 32'(o_ready), 32'd0);
      chk("full_valid", 32'(o_valid), 32'h3);
      chk("full_inst0", o_inst0, 32'h100);
      chk("full_inst1", o_inst1, 32'h101);

      // Push into a full buffer is ignored
      set_push(2'b11, 32'hDEAD0000, 32'h1C00F000, 32'hDEAD0001, 32'h1C00F004);
      step();
      set_push(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      chk("ovf_count", 32'(o_count), 32'd16);
      chk("ovf_inst0", o_inst0, 32'h100);
      chk("ovf_pc1", o_pc1, 32'h1C001004);

      // Down to 15, then pop one while offering a dual push
      i_pop = 2'b01;
      step();
      chk("c15_count", 32'(o_count), 32'd15);
      chk("c15_ready", 32'(o_ready), 32'd0);
      set_push(2'b11, 32'hBEEF0000, 32'h1C00E000, 32'hBEEF0001, 32'h1C00E004);
      step();
      set_push(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      i_pop = 2'b00;
      chk("c14_count", 32'(o_count), 32'd14);
      chk("c14_ready", 32'(o_ready), 32'd1);
      chk("c14_inst0", o_inst0, 32'h102);

      // Drain in order: remaining entries 0x102..0x10F
      for (int j = 0; j < 7; j++) begin
         chk("drain_inst0", o_inst0, 32'h102 + 32'(2*j));
         chk("drain_inst1", o_inst1, 32'h103 + 32'(2*j));
         i_pop = 2'b11;
         step();
      end
      i_pop = 2'b00;
      chk("drain_count", 32'(o_count), 32'd0);

      // Streaming: push 2 / pop 2 for 20 cycles from an odd pointer (wraps 15->0)
      set_push(2'b11, 32'h200, 32'h1C002000, 32'h201, 32'h1C002004);
      step();
      for (int c = 0; c < 20; c++) begin
         chk("strm_inst0", o_inst0, 32'h200 + 32'(2*c));
         chk("strm_inst1", o_inst1, 32'h201 + 32'(2*c));
         chk("strm_pc1", o_pc1, 32'h1C002004 + 32'(8*c));
         chk("strm_count", 32'(o_count), 32'd2);
         set_push(2'b11, 32'h202 + 32'(2*c), 32'h1C002008 + 32'(8*c),
                  32'h203 + 32'(2*c), 32'h1C00200C + 32'(8*c));
         i_pop = 2'b11;
         step();
      end
      set_push(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      chk("strm_end_inst0", o_inst0, 32'h228);
      i_pop = 2'b11;
      step();
      i_pop = 2'b00;
      chk("strm_end_count", 32'(o_count), 32'd0);

      // Flush with count=6 and same-cycle push/pop
      for (int k = 0; k < 3; k++) begin
         set_push(2'b11, 32'h300 + 32'(2*k), 32'h1C003000 + 32'(8*k),
                  32'h301 + 32'(2*k), 32'h1C003004 + 32'(8*k));
         step();
      end
      chk("pre_flush_count", 32'(o_count), 32'd6);
      set_push(2'b11, 32'h3F0, 32'h1C003F00, 32'h3F1, 32'h1C003F04);
      i_pop   = 2'b11;
      i_flush = 1'b1;
      step();
      i_flush = 1'b0;
      i_pop   = 2'b00;
      set_push(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      chk("flush_count", 32'(o_count), 32'd0);
      chk("flush_valid", 32'(o_valid), 32'h0);
      chk("flush_ready", 32'(o_ready), 32'd1);
      set_push(2'b01, 32'h0280ABCD, 32'h1C004000, 32'h0, 32'h0);
      step();
      set_push(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      chk("post_flush_valid", 32'(o_valid), 32'h1);
      chk("post_flush_inst0", o_inst0, 32'h0280ABCD);
      chk("post_flush_pc0", o_pc0, 32'h1C004000);
      chk("post_flush_count", 32'(o_count), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
